i2c_rx_byte_fifo: RTL and testbench

// - Downstream of the I2C master in the DDC/EDID read path, in the clk_4MHz (PLL) domain.
// - Takes the master's serial read bits, assembles them into MSB-first bytes and buffers them in a FIFO.
// - Keeps a per-transaction byte count, so downstream logic pops whole bytes instead of a raw bit vector.

---
 rtl/i2c_rx_byte_fifo.sv | 154 +++++++++++++++
 tb/tb_i2c_rx_byte_fifo.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_rx_byte_fifo.sv
// Assembles MSB-first I2C read bits into bytes, buffers them in a show-ahead FIFO and counts bytes per transaction.
// Optional EDID block checksum: define I2C_RX_CHECKSUM_EN.
module i2c_rx_byte_fifo #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned BLOCK_LEN = 128
) (
    input  logic                     clk_4MHz,
    input  logic                     rst_n,
    input  logic                     xfer_start,
    input  logic                     xfer_stop,
    input  logic                     bit_valid,
    input  logic                     bit_data,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     byte_done,
    output logic [7:0]               bytes_rx,
    output logic                     overflow,
    output logic                     block_done,
    output logic                     checksum_ok
);
    localparam int unsigned PW = $clog2(DEPTH);

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e         state_q, state_d;
    logic [6:0]     shift_q, shift_d;
    logic [2:0]     bitcnt_q, bitcnt_d, cnt_base;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]    count_q, count_d;
    logic [7:0]     bytes_q, bytes_d;
    logic           ovf_q, ovf_d, done_q, done_d;
    logic [7:0]     mem_q [DEPTH];

    logic           start, stop, take, push, pop, wr_ok;
    logic [7:0]     new_byte;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (PW+1)'(DEPTH));
    assign rd_data  = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign count    = count_q;
    assign bytes_rx = bytes_q;
    assign overflow = ovf_q;
    assign byte_done = done_q;

    always_comb begin
        start    = xfer_start;
        stop     = xfer_stop & ~xfer_start;
        state_d  = state_q;
        if (start)
            state_d = SHIFT;
        else if (stop)
            state_d = IDLE;

        // A START in the same cycle as a bit re-opens the transaction and then accepts the bit.
        take     = bit_valid & (start | ((state_q == SHIFT) & ~stop));
        cnt_base = (start | stop) ? 3'd0 : bitcnt_q;
        new_byte = {shift_q, bit_data};
        push     = take & (cnt_base == 3'd7);
        bitcnt_d = take ? cnt_base + 3'd1 : cnt_base;
        shift_d  = take ? {shift_q[5:0], bit_data} : shift_q;

        pop      = rd_en & ~empty;
        wr_ok    = push & (~full | pop);
        wr_ptr_d = wr_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({wr_ok, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase

        bytes_d  = (start ? 8'h00 : bytes_q) + 8'(push);
        ovf_d    = (~start & ovf_q) | (push & full & ~pop);
        done_d   = push;
    end

    always_ff @(posedge clk_4MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bitcnt_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            bytes_q  <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            bytes_q  <= bytes_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge clk_4MHz) begin
        if (wr_ok)
            mem_q[wr_ptr_q] <= new_byte;
    end

`ifdef I2C_RX_CHECKSUM_EN
    localparam int unsigned BW = $clog2(BLOCK_LEN + 1);

    logic [7:0]    sum_q, sum_d, sum_next;
    logic [BW-1:0] blk_q, blk_d, blk_base;
    logic          cks_q, cks_d, bdone_q, bdone_d, last;

    // Dropped bytes still feed the sum: the checksum covers what was on the bus.
    always_comb begin
        blk_base = start ? '0 : blk_q;
        sum_next = (start ? 8'h00 : sum_q) + (push ? new_byte : 8'h00);
        last     = push & (blk_base == BW'(BLOCK_LEN - 1));
        bdone_d  = last;
        cks_d    = cks_q;
        sum_d    = sum_next;
        blk_d    = push ? blk_base + BW'(1) : blk_base;
        if (last) begin
            cks_d = (sum_next == 8'h00);
            sum_d = 8'h00;
            blk_d = '0;
        end
    end

    always_ff @(posedge clk_4MHz or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            blk_q   <= '0;
            cks_q   <= 1'b0;
            bdone_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            blk_q   <= blk_d;
            cks_q   <= cks_d;
            bdone_q <= bdone_d;
        end
    end

    assign block_done  = bdone_q;
    assign checksum_ok = cks_q;
`else
    assign block_done  = 1'b0;
    assign checksum_ok = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_rx_byte_fifo.sv
// Self-checking bench for i2c_rx_byte_fifo: queue-based reference model, directed cases and random traffic.
module tb_i2c_rx_byte_fifo;
    localparam int unsigned DEPTH     = 16;
    localparam int unsigned BLOCK_LEN = 128;

    logic clk = 1'b0, rst_n = 1'b0;
    logic xfer_start = 1'b0, xfer_stop = 1'b0, bit_valid = 1'b0, bit_data = 1'b0, rd_en = 1'b0;
    logic [7:0] rd_data, bytes_rx;
    logic empty, full, byte_done, overflow, block_done, checksum_ok;
    logic [$clog2(DEPTH):0] count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    i2c_rx_byte_fifo #(.DEPTH(DEPTH), .BLOCK_LEN(BLOCK_LEN)) dut (
        .clk_4MHz(clk), .rst_n(rst_n), .xfer_start(xfer_start), .xfer_stop(xfer_stop),
        .bit_valid(bit_valid), .bit_data(bit_data), .rd_en(rd_en), .rd_data(rd_data),
        .empty(empty), .full(full), .count(count), .byte_done(byte_done), .bytes_rx(bytes_rx),
        .overflow(overflow), .block_done(block_done), .checksum_ok(checksum_ok)
    );

    // Reference model state
    int m_q[$];
    bit m_active = 0;
    int m_nbits = 0, m_partial = 0, m_bytes_rx = 0, m_sum = 0, m_blk = 0;
    bit m_ovf = 0, m_done = 0, m_blk_done = 0, m_cks_ok = 0;

    task automatic model_reset();
        m_q.delete();
        m_active = 0; m_nbits = 0; m_partial = 0; m_bytes_rx = 0; m_sum = 0; m_blk = 0;
        m_ovf = 0; m_done = 0; m_blk_done = 0; m_cks_ok = 0;
    endtask

    task automatic model_step();
        bit st, sp, full_before, do_pop;
        int b;
        st = xfer_start;
        sp = xfer_stop && !xfer_start;
        m_done = 0;
        m_blk_done = 0;
        full_before = (m_q.size() == DEPTH);
        do_pop = rd_en && (m_q.size() > 0);
        b = -1;
        if (st) begin
            m_active = 1; m_nbits = 0; m_partial = 0; m_bytes_rx = 0; m_ovf = 0; m_sum = 0; m_blk = 0;
        end else if (sp) begin
            m_active = 0; m_nbits = 0; m_partial = 0;
        end
        if (bit_valid && m_active) begin
            m_partial = m_partial * 2 + int'(bit_data);
            m_nbits++;
            if (m_nbits == 8) begin
                b = m_partial; m_nbits = 0; m_partial = 0;
            end
        end
        if (do_pop) void'(m_q.pop_front());
        if (b >= 0) begin
            m_done = 1;
            m_bytes_rx = (m_bytes_rx + 1) % 256;
            if (full_before && !do_pop) m_ovf = 1;
            else m_q.push_back(b);
            m_sum = (m_sum + b) % 256;
            m_blk++;
            if (m_blk == BLOCK_LEN) begin
                m_blk_done = 1; m_cks_ok = (m_sum == 0); m_sum = 0; m_blk = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else model_step();
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("empty", 32'(empty), 32'(m_q.size() == 0));
            chk("full", 32'(full), 32'(m_q.size() == DEPTH));
            chk("count", 32'(count), 32'(m_q.size()));
            if (m_q.size() > 0) chk("rd_data", 32'(rd_data), 32'(m_q[0]));
            chk("byte_done", 32'(byte_done), 32'(m_done));
            chk("bytes_rx", 32'(bytes_rx), 32'(m_bytes_rx));
            chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef I2C_RX_CHECKSUM_EN
            chk("block_done", 32'(block_done), 32'(m_blk_done));
            chk("checksum_ok", 32'(checksum_ok), 32'(m_cks_ok));
`else
            chk("block_done", 32'(block_done), 32'd0);
            chk("checksum_ok", 32'(checksum_ok), 32'd0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1; bit_data = b;
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic do_start();
        xfer_start = 1'b1; tick(); xfer_start = 1'b0;
    endtask

    task automatic do_stop();
        xfer_stop = 1'b1; tick(); xfer_stop = 1'b0;
    endtask

    task automatic do_pop();
        rd_en = 1'b1; tick(); rd_en = 1'b0;
    endtask

    initial begin
        logic [7:0] ee;
        #20;
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_full", 32'(full), 32'd0);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_rd_data", 32'(rd_data), 32'h00);
        chk("reset_overflow", 32'(overflow), 32'd0);
        chk("reset_byte_done", 32'(byte_done), 32'd0);
        #3 rst_n = 1'b1;
        tick();

        // Basic byte 0,1,0,1,0,0,0,0 -> 8'h50
        do_start();
        send_byte(8'h50);
        chk("t1_byte_done", 32'(byte_done), 32'd1);
        chk("t1_rd_data", 32'(rd_data), 32'h50);
        chk("t1_count", 32'(count), 32'd1);
        chk("t1_empty", 32'(empty), 32'd0);
        chk("t1_bytes_rx", 32'(bytes_rx), 32'd1);
        do_pop();

        // Fill past capacity
        do_start();
        for (int i = 0; i <= 16; i++) send_byte(8'(i));
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_count", 32'(count), 32'd16);
        chk("t2_overflow", 32'(overflow), 32'd1);
        chk("t2_bytes_rx", 32'(bytes_rx), 32'd17);
        for (int i = 0; i < 16; i++) begin
            chk("t2_pop_data", 32'(rd_data), 32'(i));
            do_pop();
        end
        chk("t2_drained", 32'(empty), 32'd1);

        // Push into full FIFO with simultaneous pop
        do_start();
        for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i));
        ee = 8'hEE;
        for (int i = 7; i >= 1; i--) send_bit(ee[i]);
        rd_en = 1'b1;
        send_bit(ee[0]);
        rd_en = 1'b0;
        chk("t3_count", 32'(count), 32'd16);
        chk("t3_overflow", 32'(overflow), 32'd0);
        chk("t3_head", 32'(rd_data), 32'h21);
        for (int i = 0; i < 16; i++) begin
            chk("t3_pop_data", 32'(rd_data), (i < 15) ? 32'(8'h21 + 8'(i)) : 32'hEE);
            do_pop();
        end

        // Partial byte discarded by STOP, then repeated START
        do_start();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        do_stop();
        do_start();
        send_byte(8'hA5);
        chk("t4_count", 32'(count), 32'd1);
        chk("t4_rd_data", 32'(rd_data), 32'hA5);
        chk("t4_bytes_rx", 32'(bytes_rx), 32'd1);
        do_pop();

`ifdef I2C_RX_CHECKSUM_EN
        do_start();
        for (int i = 0; i < 127; i++) send_byte(8'h01);
        send_byte(8'h81);
        chk("cs1_block_done", 32'(block_done), 32'd1);
        chk("cs1_checksum_ok", 32'(checksum_ok), 32'd1);
        for (int i = 0; i < 127; i++) send_byte(8'h00);
        send_byte(8'h01);
        chk("cs2_block_done", 32'(block_done), 32'd1);
        chk("cs2_checksum_ok", 32'(checksum_ok), 32'd0);
        for (int i = 0; i < 16; i++) do_pop();
`endif

        // Random traffic in two pop-rate regimes
        do_start();
        for (int i = 0; i < 4000; i++) begin
            xfer_start = ($urandom_range(0, 79) == 0);
            xfer_stop  = ($urandom_range(0, 79) == 0);
            bit_valid  = ($urandom_range(0, 2) != 0);
            bit_data   = 1'($urandom_range(0, 1));
            rd_en      = (i < 2000) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 0);
            tick();
        end
        xfer_start = 1'b0; xfer_stop = 1'b0; bit_valid = 1'b0; rd_en = 1'b0;
        for (int i = 0; i < 20; i++) do_pop();

        // Asynchronous reset mid-byte with bytes queued
        do_start();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        chk("rst_pre_count", 32'(count), 32'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_empty", 32'(empty), 32'd1);
        chk("rst_async_count", 32'(count), 32'd0);
        chk("rst_async_overflow", 32'(overflow), 32'd0);
        chk("rst_async_bytes_rx", 32'(bytes_rx), 32'd0);
        #9 rst_n = 1'b1;
        tick();
        send_byte(8'h3C);
        chk("post_rst_ignored", 32'(count), 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
